param_dpram: RTL and testbench

//   Parametrised simple dual-port RAM: one write port, one read port, single clock.

---
 rtl/param_dpram.sv | 92 +++++++++
 tb/tb_param_dpram.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/param_dpram.sv
// param_dpram: parameterised one-write/one-read RAM with power-up clear, read-valid strobe and RD_LAT 1/2.
// Define DPRAM_BYPASS_EN for write-first collisions; the default build is read-first.
module param_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              init_busy_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run, rd_fire, mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd, rd_src, rd1_q, rd1_d;
  logic              v1_q;

  // The clear sequencer owns the write port until every word has been zeroed
  assign run     = state_q == RUN;
  assign rd_fire = run && rd_en_i;
  assign mem_we  = !run || wr_en_i;
  assign mem_wa  = run ? wr_addr_i : clr_cnt_q;
  assign mem_wd  = run ? wr_data_i : '0;

`ifdef DPRAM_BYPASS_EN
  assign rd_src = (wr_en_i && wr_addr_i == rd_addr_i) ? wr_data_i : mem[rd_addr_i];
`else
  assign rd_src = mem[rd_addr_i];
`endif

  always_comb begin
    state_d   = (!run && &clr_cnt_q) ? RUN : state_q;
    clr_cnt_d = run ? clr_cnt_q : clr_cnt_q + 1'b1;
    busy_d    = state_d == INIT;
    rd1_d     = rd_fire ? rd_src : rd1_q;
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      rd1_q     <= '0;
      v1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      rd1_q     <= rd1_d;
      v1_q      <= rd_fire;
    end
  end

  always_ff @(posedge clock_i) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd2_q;
      logic              v2_q;
      always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd2_q <= '0;
          v2_q  <= 1'b0;
        end else begin
          rd2_q <= v1_q ? rd1_q : rd2_q;
          v2_q  <= v1_q;
        end
      end
      assign rd_data_o  = rd2_q;
      assign rd_valid_o = v2_q;
    end else begin : g_lat1
      assign rd_data_o  = rd1_q;
      assign rd_valid_o = v1_q;
    end
  endgenerate

  assign init_busy_o = busy_q;
endmodule

// File: tb/tb_param_dpram.sv
// tb_param_dpram: drives a RD_LAT=1/8-bit and a RD_LAT=2/16-bit instance with identical stimulus
// and checks both every cycle against an array-based model of the memory and read results.
module tb_param_dpram;
`ifdef DPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, we, re;
  logic [7:0]  wa, ra;
  logic [15:0] wd;
  logic [7:0]  d1;
  logic [15:0] d2;
  logic        v1, v2, b1, b2;

  int n_chk, n_fail;

  logic [15:0] mem_m [256];
  int          clr_left;
  logic        h0v, h1v, e1v, e2v;
  logic [15:0] h0d, h1d, e1d, e2d;

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic        ev;
    logic [7:0]  ed;
  } vec_t;
  vec_t tbl[$];

  param_dpram #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1)) u_lat1 (
    .clock_i(clk), .rst_ni(rst_n), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd[7:0]),
    .rd_en_i(re), .rd_addr_i(ra), .rd_data_o(d1), .rd_valid_o(v1), .init_busy_o(b1));

  param_dpram #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2)) u_lat2 (
    .clock_i(clk), .rst_ni(rst_n), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
    .rd_en_i(re), .rd_addr_i(ra), .rd_data_o(d2), .rd_valid_o(v2), .init_busy_o(b2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at the next negedge
  task automatic cyc(input logic we_i, input logic [7:0] wa_i, input logic [15:0] wd_i,
                     input logic re_i, input logic [7:0] ra_i);
    logic        rv;
    logic [15:0] rdv;
    we = we_i; wa = wa_i; wd = wd_i; re = re_i; ra = ra_i;
    @(posedge clk);
    rv = 1'b0;
    rdv = '0;
    if (clr_left > 0) clr_left--;
    else begin
      rv  = re_i;
      rdv = (BYP && we_i && wa_i == ra_i) ? wd_i : mem_m[ra_i];
      if (we_i) mem_m[wa_i] = wd_i;
    end
    h1v = h0v; h1d = h0d; h0v = rv; h0d = rdv;
    e1v = h0v; if (h0v) e1d = h0d;
    e2v = h1v; if (h1v) e2d = h1d;
    @(negedge clk);
    chk("busy1", {15'd0, b1}, {15'd0, clr_left > 0});
    chk("busy2", {15'd0, b2}, {15'd0, clr_left > 0});
    chk("valid1", {15'd0, v1}, {15'd0, e1v});
    chk("valid2", {15'd0, v2}, {15'd0, e2v});
    chk("data1", {8'd0, d1}, {8'd0, e1d[7:0]});
    chk("data2", d2, e2d);
  endtask

  task automatic idle();
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    we = 0; re = 0; wa = 0; ra = 0; wd = 0;
    rst_n = 1'b0;
    #1;
    clr_left = 256;
    foreach (mem_m[i]) mem_m[i] = '0;
    h0v = 0; h1v = 0; h0d = 0; h1d = 0; e1v = 0; e2v = 0; e1d = 0; e2d = 0;
    chk("rst_data1", {8'd0, d1}, 16'd0);
    chk("rst_data2", d2, 16'd0);
    chk("rst_valid", {14'd0, v1, v2}, 16'd0);
    chk("rst_busy", {14'd0, b1, b2}, 16'd3);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_busy(input int start, input int exp_len);
    int n = start;
    while (b1 && n < 400) begin
      idle();
      n++;
    end
    chk("busy_len", 16'(n), 16'(exp_len));
  endtask

  task automatic sweep_zero();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 8'd0, 16'd0, 1'b1, 8'(i));
      if (i > 0) chk("sweep_zero", {7'd0, v1, d1}, 16'h0100);
    end
    idle();
    idle();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    count_busy(0, 256);
    sweep_zero();

    for (int i = 0; i < 16; i++) tbl.push_back('{1'b1, 8'(i), 16'(255 - i), 1'b0, 8'd0, 1'b0, 8'd0});
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 8'd0, 16'd0, 1'b1, 8'(i), 1'b1, 8'(255 - i)});
    tbl.push_back('{1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 8'd5, 16'h00FA, 1'b0, 8'd0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 8'd5, 16'h00A5, 1'b1, 8'd5, 1'b1, BYP ? 8'hA5 : 8'hFA});
    tbl.push_back('{1'b0, 8'd0, 16'd0, 1'b1, 8'd5, 1'b1, 8'hA5});
    tbl.push_back('{1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 8'd0});
    foreach (tbl[k]) begin
      cyc(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].re, tbl[k].ra);
      chk("tbl_valid", {15'd0, v1}, {15'd0, tbl[k].ev});
      if (tbl[k].ev) chk("tbl_data", {8'd0, d1}, {8'd0, tbl[k].ed});
    end

    cyc(1'b1, 8'd3, 16'h1234, 1'b0, 8'd0);
    cyc(1'b0, 8'd0, 16'd0, 1'b1, 8'd3);
    chk("lat2_early", {15'd0, v2}, 16'd0);
    idle();
    chk("lat2_valid", {15'd0, v2}, 16'd1);
    chk("lat2_data", d2, 16'h1234);
    idle();
    chk("lat2_drop", {15'd0, v2}, 16'd0);
    chk("lat2_hold", d2, 16'h1234);

    do_reset();
    cyc(1'b1, 8'd7, 16'h0055, 1'b1, 8'd7);
    chk("init_novalid", {14'd0, v1, v2}, 16'd0);
    count_busy(1, 256);
    cyc(1'b0, 8'd0, 16'd0, 1'b1, 8'd7);
    chk("init_wr_ignored", {7'd0, v1, d1}, 16'h0100);
    idle();

    do_reset();
    repeat (100) idle();
    do_reset();
    count_busy(0, 256);
    sweep_zero();

    repeat (3000) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
